// File: rtl/uart_frame_parser_if.sv
// Byte-wide AXI-Stream link used on both sides of the frame parser.
// The receive side carries no tlast; only the master modport drives it.
interface uart_frame_parser_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;

    modport master (output tdata, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser for 0x55 0xAA LEN payload[LEN] CHK packets arriving from the
// UART receiver. Payloads are buffered, checksum-verified and only good ones
// are replayed on m_axis with tlast; bad frames are dropped and counted.
module uart_frame_parser #(
    parameter int unsigned MAX_LEN        = 16,
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  HDR0           = 8'h55,
    parameter logic [7:0]  HDR1           = 8'hAA
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_frame_parser_if.slave   s_axis,
    uart_frame_parser_if.master  m_axis,
    output logic                 frame_ok,
    output logic                 frame_err,
    output logic [1:0]           err_code,
    output logic [15:0]          ok_cnt,
    output logic [15:0]          err_cnt
);

    localparam int unsigned AW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned DEPTH   = 1 << AW;
    localparam logic [7:0]  MAX_B   = 8'(MAX_LEN);
    localparam logic [31:0] TMO_LIM = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_LEN = 2'd1;
    localparam logic [1:0] ERR_CHK = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {
        HUNT0,
        HUNT1,
        LEN,
        PAY,
        CHK,
        OUT
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  len_q, len_d;
    logic [7:0]  wptr_q, wptr_d;
    logic [7:0]  rptr_q, rptr_d;
    logic [7:0]  sum_q, sum_d;
    logic [31:0] tmo_q, tmo_d;
    logic [7:0]  m_tdata_q, m_tdata_d;
    logic        m_tvalid_q, m_tvalid_d;
    logic        m_tlast_q, m_tlast_d;
    logic        frame_ok_q, frame_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [1:0]  err_code_q, err_code_d;
    logic [15:0] ok_cnt_q, ok_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    logic [7:0]  pay_mem [0:DEPTH-1];
    logic        mem_we;

    logic        s_ready;
    logic        s_hs;
    logic        m_hs;
    logic        tmo_hit;
    logic        err_hit;
    logic [1:0]  err_val;
    logic [7:0]  rptr_nx;

    assign s_ready = rst_n && (state_q != OUT);
    assign s_hs    = s_axis.tvalid && s_ready;
    assign m_hs    = m_tvalid_q && m_axis.tready;
    assign tmo_hit = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LIM);
    assign rptr_nx = rptr_q + 8'd1;

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = m_tdata_q;
    assign m_axis.tvalid = m_tvalid_q;
    assign m_axis.tlast  = m_tlast_q;
    assign frame_ok      = frame_ok_q;
    assign frame_err     = frame_err_q;
    assign err_code      = err_code_q;
    assign ok_cnt        = ok_cnt_q;
    assign err_cnt       = err_cnt_q;

    // Next-state, datapath and status computation for the framing FSM
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        sum_d       = sum_q;
        tmo_d       = tmo_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        frame_ok_d  = 1'b0;
        frame_err_d = 1'b0;
        err_code_d  = err_code_q;
        ok_cnt_d    = ok_cnt_q;
        err_cnt_d   = err_cnt_q;
        mem_we      = 1'b0;
        err_hit     = 1'b0;
        err_val     = 2'd0;

        unique case (state_q)
            HUNT0: begin
                if (s_hs && s_axis.tdata == HDR0) state_d = HUNT1;
            end
            HUNT1: begin
                if (s_hs) begin
                    if (s_axis.tdata == HDR1)      state_d = LEN;
                    else if (s_axis.tdata == HDR0) state_d = HUNT1;
                    else                           state_d = HUNT0;
                end else if (tmo_hit) begin
                    err_hit = 1'b1;
                    err_val = ERR_TMO;
                end
            end
            LEN: begin
                if (s_hs) begin
                    if (s_axis.tdata != 8'd0 && s_axis.tdata <= MAX_B) begin
                        len_d   = s_axis.tdata;
                        sum_d   = s_axis.tdata;
                        wptr_d  = '0;
                        state_d = PAY;
                    end else begin
                        err_hit = 1'b1;
                        err_val = ERR_LEN;
                    end
                end else if (tmo_hit) begin
                    err_hit = 1'b1;
                    err_val = ERR_TMO;
                end
            end
            PAY: begin
                if (s_hs) begin
                    mem_we = 1'b1;
                    sum_d  = sum_q + s_axis.tdata;
                    wptr_d = wptr_q + 8'd1;
                    if (wptr_q == len_q - 8'd1) state_d = CHK;
                end else if (tmo_hit) begin
                    err_hit = 1'b1;
                    err_val = ERR_TMO;
                end
            end
            CHK: begin
                if (s_hs) begin
                    if (s_axis.tdata == sum_q) begin
                        frame_ok_d = 1'b1;
                        ok_cnt_d   = ok_cnt_q + 16'd1;
                        rptr_d     = '0;
                        m_tdata_d  = pay_mem[0];
                        m_tvalid_d = 1'b1;
                        m_tlast_d  = (len_q == 8'd1);
                        state_d    = OUT;
                    end else begin
                        err_hit = 1'b1;
                        err_val = ERR_CHK;
                    end
                end else if (tmo_hit) begin
                    err_hit = 1'b1;
                    err_val = ERR_TMO;
                end
            end
            OUT: begin
                // Output registers are preloaded one byte ahead so data,
                // valid and last stay put while downstream stalls.
                if (m_hs) begin
                    if (m_tlast_q) begin
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                        state_d    = HUNT0;
                    end else begin
                        rptr_d    = rptr_nx;
                        m_tdata_d = pay_mem[rptr_nx[AW-1:0]];
                        m_tlast_d = (rptr_nx == len_q - 8'd1);
                    end
                end
            end
            default: state_d = HUNT0;
        endcase

        if (err_hit) begin
            frame_err_d = 1'b1;
            err_code_d  = err_val;
            err_cnt_d   = err_cnt_q + 16'd1;
            state_d     = HUNT0;
        end

        if (TIMEOUT_CYCLES == 0 || s_hs || state_d == HUNT0 || state_d == OUT)
            tmo_d = '0;
        else
            tmo_d = tmo_q + 32'd1;
    end

    // State and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= HUNT0;
            len_q       <= '0;
            wptr_q      <= '0;
            rptr_q      <= '0;
            sum_q       <= '0;
            tmo_q       <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_code_q  <= '0;
            ok_cnt_q    <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            sum_q       <= sum_d;
            tmo_q       <= tmo_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            frame_ok_q  <= frame_ok_d;
            frame_err_q <= frame_err_d;
            err_code_q  <= err_code_d;
            ok_cnt_q    <= ok_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    // Payload buffer write port; contents need no reset
    always_ff @(posedge clk) begin
        if (mem_we) pay_mem[wptr_q[AW-1:0]] <= s_axis.tdata;
    end

endmodule
